context_switch_unit: RTL and testbench



---
 rtl/context_switch_unit.sv | 173 +++++++++++++++++
 tb/tb_context_switch_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/context_switch_unit.sv
// context_switch_unit
//   Saves and restores the architectural register file through the
//   register_memory snapshot store.
//   SAVE    : reads x0..x31 one per cycle over the asynchronous RF read port.
//             It packs them with the PC captured at SAVE into a 1024+32 bit
//             snapshot, then issues a single STORE_WRITE.
//   RESTORE : issues a single STORE_READ and waits STORE_LATENCY cycles.
//             It latches the returned snapshot, writes x1..x31 back one per
//             cycle, then presents the restored PC to fetch.
// Ports
//   CLK, RESET                  clock, synchronous active-high reset
//   SAVE, RESTORE, PC_IN        requests (sampled only when idle), current PC
//   RF_READ_ADDR/RF_READ_DATA   register-file read port (async read)
//   RF_WRITE_EN/ADDR/DATA       register-file write port
//   STORE_WRITE, STORE_READ     one-cycle store strobes
//   STORE_DATA_OUT/STORE_PC_OUT snapshot to store (reg n at [32n+31:32n])
//   STORE_DATA_IN/STORE_PC_IN   snapshot from store, same packing
//   PC_RESTORE(_VALID)          restored PC and its one-cycle qualifier
//   BUSY, DONE                  not-idle flag, one-cycle completion strobe
module context_switch_unit #(
  parameter int unsigned STORE_LATENCY = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          SAVE,
  input  logic          RESTORE,
  input  logic [31:0]   PC_IN,
  output logic [4:0]    RF_READ_ADDR,
  input  logic [31:0]   RF_READ_DATA,
  output logic          RF_WRITE_EN,
  output logic [4:0]    RF_WRITE_ADDR,
  output logic [31:0]   RF_WRITE_DATA,
  output logic          STORE_WRITE,
  output logic          STORE_READ,
  output logic [1023:0] STORE_DATA_OUT,
  output logic [31:0]   STORE_PC_OUT,
  input  logic [1023:0] STORE_DATA_IN,
  input  logic [31:0]   STORE_PC_IN,
  output logic [31:0]   PC_RESTORE,
  output logic          PC_RESTORE_VALID,
  output logic          BUSY,
  output logic          DONE
);

  localparam logic [3:0] LP_LAT = 4'(STORE_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATHER,
    S_COMMIT,
    S_REQ,
    S_WAIT,
    S_SCATTER,
    S_FINISH
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [4:0]    r_idx;
  logic [3:0]    r_cnt;
  logic [1023:0] r_save_data;
  logic [31:0]   r_save_pc;
  logic [1023:0] r_rest_data;
  logic [31:0]   r_rest_pc;
  logic [9:0]    w_slot_off;

  assign w_slot_off = {r_idx, 5'b0};

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath: index, wait counter and the two snapshot buffers.
  // Save and restore snapshots live in separate buffers so that a restore
  // never disturbs the last saved snapshot on STORE_DATA_OUT.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_save_data <= '0;
      r_save_pc   <= '0;
      r_rest_data <= '0;
      r_rest_pc   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (SAVE) begin
            r_save_pc <= PC_IN;
            r_idx     <= '0;
          end
        end
        S_GATHER: begin
          r_save_data[w_slot_off +: 32] <= (r_idx == 5'd0) ? '0 : RF_READ_DATA;
          if (r_idx != 5'd31) r_idx <= r_idx + 5'd1;
        end
        S_REQ: begin
          r_cnt <= LP_LAT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_rest_data <= STORE_DATA_IN;
            r_rest_pc   <= STORE_PC_IN;
            r_idx       <= 5'd1;
          end
        end
        S_SCATTER: begin
          if (r_idx != 5'd31) r_idx <= r_idx + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_next           = r_state;
    RF_READ_ADDR     = '0;
    RF_WRITE_EN      = 1'b0;
    RF_WRITE_ADDR    = '0;
    RF_WRITE_DATA    = '0;
    STORE_WRITE      = 1'b0;
    STORE_READ       = 1'b0;
    PC_RESTORE       = '0;
    PC_RESTORE_VALID = 1'b0;
    DONE             = 1'b0;
    BUSY             = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (SAVE)         w_next = S_GATHER;
        else if (RESTORE) w_next = S_REQ;
      end
      S_GATHER: begin
        RF_READ_ADDR = r_idx;
        if (r_idx == 5'd31) w_next = S_COMMIT;
      end
      S_COMMIT: begin
        STORE_WRITE = 1'b1;
        DONE        = 1'b1;
        w_next      = S_IDLE;
      end
      S_REQ: begin
        STORE_READ = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) w_next = S_SCATTER;
      end
      S_SCATTER: begin
        RF_WRITE_EN   = 1'b1;
        RF_WRITE_ADDR = r_idx;
        RF_WRITE_DATA = r_rest_data[w_slot_off +: 32];
        if (r_idx == 5'd31) w_next = S_FINISH;
      end
      S_FINISH: begin
        PC_RESTORE       = r_rest_pc;
        PC_RESTORE_VALID = 1'b1;
        DONE             = 1'b1;
        w_next           = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign STORE_DATA_OUT = r_save_data;
  assign STORE_PC_OUT   = r_save_pc;

endmodule

// File: tb/tb_context_switch_unit.sv
// Bench for context_switch_unit: three instances with store latency 2, 1 and
// 15, each attached to a register-file model and a snapshot-store model.
// Expected timing and data are derived from the operation rules.
module tb_context_switch_unit;

  logic          CLK;
  logic          RESET;
  logic          sv     [3];
  logic          rs     [3];
  logic [31:0]   pcin   [3];
  logic [4:0]    raddr  [3];
  logic [31:0]   rdata  [3];
  logic          we     [3];
  logic [4:0]    wa     [3];
  logic [31:0]   wd     [3];
  logic          sw     [3];
  logic          sr     [3];
  logic [1023:0] sdout  [3];
  logic [31:0]   spout  [3];
  logic [1023:0] sdin   [3];
  logic [31:0]   spin   [3];
  logic [31:0]   pcr    [3];
  logic          pvld   [3];
  logic          busy   [3];
  logic          done   [3];

  // Environment models
  logic [31:0]   rf     [3][32];
  logic [1023:0] mem    [3];
  logic [31:0]   mem_pc [3];
  int            lat    [3];
  int            rd_cyc [3];
  int            cyc;

  // Event statistics
  int n_sw[3], c_sw[3], n_sr[3], c_sr[3], n_done[3], c_done[3];
  int n_pv[3], c_pv[3], n_wr[3], c_wr_first[3], c_wr_last[3];
  int wr_op[3], exp_wa[3], seq_err[3], wr_x0[3], n_busy[3];
  logic [31:0] v_pc[3];

  int n_vec;
  int n_err;

  context_switch_unit #(.STORE_LATENCY(2)) u0 (
    .CLK(CLK), .RESET(RESET), .SAVE(sv[0]), .RESTORE(rs[0]), .PC_IN(pcin[0]),
    .RF_READ_ADDR(raddr[0]), .RF_READ_DATA(rdata[0]), .RF_WRITE_EN(we[0]),
    .RF_WRITE_ADDR(wa[0]), .RF_WRITE_DATA(wd[0]), .STORE_WRITE(sw[0]),
    .STORE_READ(sr[0]), .STORE_DATA_OUT(sdout[0]), .STORE_PC_OUT(spout[0]),
    .STORE_DATA_IN(sdin[0]), .STORE_PC_IN(spin[0]), .PC_RESTORE(pcr[0]),
    .PC_RESTORE_VALID(pvld[0]), .BUSY(busy[0]), .DONE(done[0]));

  context_switch_unit #(.STORE_LATENCY(1)) u1 (
    .CLK(CLK), .RESET(RESET), .SAVE(sv[1]), .RESTORE(rs[1]), .PC_IN(pcin[1]),
    .RF_READ_ADDR(raddr[1]), .RF_READ_DATA(rdata[1]), .RF_WRITE_EN(we[1]),
    .RF_WRITE_ADDR(wa[1]), .RF_WRITE_DATA(wd[1]), .STORE_WRITE(sw[1]),
    .STORE_READ(sr[1]), .STORE_DATA_OUT(sdout[1]), .STORE_PC_OUT(spout[1]),
    .STORE_DATA_IN(sdin[1]), .STORE_PC_IN(spin[1]), .PC_RESTORE(pcr[1]),
    .PC_RESTORE_VALID(pvld[1]), .BUSY(busy[1]), .DONE(done[1]));

  context_switch_unit #(.STORE_LATENCY(15)) u2 (
    .CLK(CLK), .RESET(RESET), .SAVE(sv[2]), .RESTORE(rs[2]), .PC_IN(pcin[2]),
    .RF_READ_ADDR(raddr[2]), .RF_READ_DATA(rdata[2]), .RF_WRITE_EN(we[2]),
    .RF_WRITE_ADDR(wa[2]), .RF_WRITE_DATA(wd[2]), .STORE_WRITE(sw[2]),
    .STORE_READ(sr[2]), .STORE_DATA_OUT(sdout[2]), .STORE_PC_OUT(spout[2]),
    .STORE_DATA_IN(sdin[2]), .STORE_PC_IN(spin[2]), .PC_RESTORE(pcr[2]),
    .PC_RESTORE_VALID(pvld[2]), .BUSY(busy[2]), .DONE(done[2]));

  // Asynchronous register-file read; x0 returns junk that must not be saved.
  assign rdata[0] = (raddr[0] == 5'd0) ? 32'hDEAD_BEEF : rf[0][raddr[0]];
  assign rdata[1] = (raddr[1] == 5'd0) ? 32'hDEAD_BEEF : rf[1][raddr[1]];
  assign rdata[2] = (raddr[2] == 5'd0) ? 32'hDEAD_BEEF : rf[2][raddr[2]];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1023:0] rnd1024();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Advance one cycle, observe every instance #1 after the edge, update the
  // RF and store models, and present store read data for this cycle.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (busy[k]) n_busy[k]++;
      if (sw[k]) begin
        n_sw[k]++; c_sw[k] = cyc; mem[k] = sdout[k]; mem_pc[k] = spout[k];
      end
      if (sr[k]) begin n_sr[k]++; c_sr[k] = cyc; rd_cyc[k] = cyc; end
      if (done[k]) begin n_done[k]++; c_done[k] = cyc; end
      if (pvld[k]) begin n_pv[k]++; c_pv[k] = cyc; v_pc[k] = pcr[k]; end
      if (we[k]) begin
        n_wr[k]++;
        if (wr_op[k] == 0) c_wr_first[k] = cyc;
        wr_op[k]++;
        c_wr_last[k] = cyc;
        if (int'(wa[k]) != exp_wa[k]) seq_err[k]++;
        exp_wa[k]++;
        if (wa[k] == 5'd0) wr_x0[k]++;
        rf[k][wa[k]] = wd[k];
      end
      if (cyc == rd_cyc[k] + lat[k]) begin
        sdin[k] = mem[k]; spin[k] = mem_pc[k];
      end else begin
        sdin[k] = rnd1024(); spin[k] = $urandom;
      end
    end
  endtask

  // Save on instance k; returns in the first idle cycle after DONE.
  task automatic do_save(input int k, input logic [31:0] pc, input bit with_restore);
    logic [1023:0] exp_snap;
    int t, g, sw0, sr0, dn0, by0, nbad;
    for (int n = 0; n < 32; n++) exp_snap[n*32 +: 32] = (n == 0) ? 32'h0 : rf[k][n];
    sw0 = n_sw[k]; sr0 = n_sr[k]; dn0 = n_done[k]; by0 = n_busy[k];
    t = cyc;
    sv[k] = 1'b1; rs[k] = with_restore; pcin[k] = pc;
    tick();
    sv[k] = 1'b0; rs[k] = 1'b0; pcin[k] = $urandom;
    for (g = 0; g < 100 && n_done[k] == dn0; g++) tick();
    check("save_done_seen", 64'(n_done[k] - dn0), 64'd1);
    check("save_sw_count", 64'(n_sw[k] - sw0), 64'd1);
    check("save_sw_cycle", 64'(c_sw[k] - t), 64'd33);
    check("save_done_cycle", 64'(c_done[k] - t), 64'd33);
    check("save_no_store_read", 64'(n_sr[k] - sr0), 64'd0);
    nbad = 0;
    for (int n = 0; n < 32; n++) if (mem[k][n*32 +: 32] !== exp_snap[n*32 +: 32]) nbad++;
    check("save_bad_slots", 64'(nbad), 64'd0);
    check("save_pc", {32'h0, mem_pc[k]}, {32'h0, pc});
    tick();
    check("save_idle_busy", {63'h0, busy[k]}, 64'd0);
    check("save_busy_cycles", 64'(n_busy[k] - by0), 64'd33);
    nbad = 0;
    for (int n = 0; n < 32; n++) if (sdout[k][n*32 +: 32] !== exp_snap[n*32 +: 32]) nbad++;
    check("save_hold_slots", 64'(nbad), 64'd0);
  endtask

  // Restore on instance k. save_off>0 pulses SAVE in SCATTER cycle save_off;
  // rst_off>0 asserts RESET in SCATTER cycle rst_off.
  task automatic do_restore(input int k, input logic [1023:0] data, input logic [31:0] pc,
                            input bit preload, input int save_off, input int rst_off);
    int t, L, g, sw0, sr0, dn0, pv0, nw0, sq0, x00, by0, nbad;
    bit aborted;
    L = lat[k];
    if (preload) begin mem[k] = data; mem_pc[k] = pc; end
    sw0 = n_sw[k]; sr0 = n_sr[k]; dn0 = n_done[k]; pv0 = n_pv[k];
    nw0 = n_wr[k]; sq0 = seq_err[k]; x00 = wr_x0[k]; by0 = n_busy[k];
    wr_op[k] = 0; exp_wa[k] = 1;
    t = cyc;
    rs[k] = 1'b1;
    tick();
    rs[k] = 1'b0;
    aborted = 1'b0;
    for (g = 0; g < 100 && n_pv[k] == pv0 && !aborted; g++) begin
      sv[k] = (save_off > 0 && cyc == t + 1 + L + save_off);
      if (rst_off > 0 && cyc == t + 1 + L + rst_off) begin
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        aborted = 1'b1;
      end else begin
        tick();
      end
    end
    sv[k] = 1'b0;
    if (aborted) begin
      check("rst_busy", {63'h0, busy[k]}, 64'd0);
      check("rst_we", {63'h0, we[k]}, 64'd0);
      check("rst_done", {63'h0, done[k]}, 64'd0);
      check("rst_pvld", {63'h0, pvld[k]}, 64'd0);
      for (int i = 0; i < 3; i++) tick();
      check("rst_no_done", 64'(n_done[k] - dn0), 64'd0);
      check("rst_no_pv", 64'(n_pv[k] - pv0), 64'd0);
      check("rst_wr_count", 64'(n_wr[k] - nw0), 64'(rst_off));
      check("rst_still_idle", {63'h0, busy[k]}, 64'd0);
      return;
    end
    check("rest_pv_seen", 64'(n_pv[k] - pv0), 64'd1);
    check("rest_sr_count", 64'(n_sr[k] - sr0), 64'd1);
    check("rest_sr_cycle", 64'(c_sr[k] - t), 64'd1);
    check("rest_wr_count", 64'(n_wr[k] - nw0), 64'd31);
    check("rest_wr_first", 64'(c_wr_first[k] - t), 64'(2 + L));
    check("rest_wr_last", 64'(c_wr_last[k] - t), 64'(32 + L));
    check("rest_wr_order", 64'(seq_err[k] - sq0), 64'd0);
    check("rest_wr_x0", 64'(wr_x0[k] - x00), 64'd0);
    nbad = 0;
    for (int n = 1; n < 32; n++) if (rf[k][n] !== data[n*32 +: 32]) nbad++;
    check("rest_bad_regs", 64'(nbad), 64'd0);
    check("rest_pv_cycle", 64'(c_pv[k] - t), 64'(33 + L));
    check("rest_pc", {32'h0, v_pc[k]}, {32'h0, pc});
    check("rest_done_count", 64'(n_done[k] - dn0), 64'd1);
    check("rest_done_cycle", 64'(c_done[k] - t), 64'(33 + L));
    check("rest_no_store_write", 64'(n_sw[k] - sw0), 64'd0);
    tick();
    check("rest_idle_busy", {63'h0, busy[k]}, 64'd0);
    check("rest_busy_cycles", 64'(n_busy[k] - by0), 64'(33 + L));
  endtask

  initial begin
    logic [1023:0] d;
    logic [31:0]   pc;
    logic [31:0]   orig [32];
    n_vec = 0; n_err = 0; cyc = 0;
    lat[0] = 2; lat[1] = 1; lat[2] = 15;
    for (int k = 0; k < 3; k++) begin
      sv[k] = 1'b0; rs[k] = 1'b0; pcin[k] = '0; sdin[k] = '0; spin[k] = '0;
      mem[k] = '0; mem_pc[k] = '0; rd_cyc[k] = -1000; v_pc[k] = '0;
      n_sw[k] = 0; c_sw[k] = 0; n_sr[k] = 0; c_sr[k] = 0; n_done[k] = 0; c_done[k] = 0;
      n_pv[k] = 0; c_pv[k] = 0; n_wr[k] = 0; c_wr_first[k] = 0; c_wr_last[k] = 0;
      wr_op[k] = 0; exp_wa[k] = 1; seq_err[k] = 0; wr_x0[k] = 0; n_busy[k] = 0;
      for (int n = 0; n < 32; n++) rf[k][n] = '0;
    end

    // Reset state
    RESET = 1'b1;
    tick(); tick();
    check("reset_busy", {63'h0, busy[0]}, 64'd0);
    check("reset_done", {63'h0, done[0]}, 64'd0);
    check("reset_strobes", {60'h0, sw[0], sr[0], we[0], pvld[0]}, 64'd0);
    check("reset_raddr", {59'h0, raddr[0]}, 64'd0);
    check("reset_sdout_any", {63'h0, |sdout[0]}, 64'd0);
    check("reset_spout", {32'h0, spout[0]}, 64'd0);
    check("reset_pc_restore", {32'h0, pcr[0]}, 64'd0);
    RESET = 1'b0;
    tick();

    // Directed save
    for (int n = 0; n < 32; n++) rf[0][n] = 32'hA000_0000 + 32'(n);
    do_save(0, 32'h0000_1234, 1'b0);
    check("dir_save_x1", {32'h0, mem[0][63:32]}, 64'hA000_0001);
    check("dir_save_x31", {32'h0, mem[0][1023:992]}, 64'hA000_001F);
    check("dir_save_x0", {32'h0, mem[0][31:0]}, 64'h0);

    // Directed restore, L=2
    for (int n = 0; n < 32; n++) d[n*32 +: 32] = 32'h5000_0000 + 32'(n);
    do_restore(0, d, 32'h0000_0800, 1'b1, 0, 0);
    check("dir_rest_x31", {32'h0, rf[0][31]}, 64'h5000_001F);

    // Latency sweep
    do_restore(1, rnd1024(), $urandom, 1'b1, 0, 0);
    do_restore(2, rnd1024(), $urandom, 1'b1, 0, 0);

    // SAVE and RESTORE together: save only
    for (int n = 1; n < 32; n++) rf[0][n] = $urandom;
    do_save(0, $urandom, 1'b1);

    // SAVE during SCATTER is ignored
    do_restore(0, rnd1024(), $urandom, 1'b1, 7, 0);

    // RESET in the 10th SCATTER cycle, then a normal save
    do_restore(0, rnd1024(), $urandom, 1'b1, 0, 10);
    for (int n = 1; n < 32; n++) rf[0][n] = $urandom;
    do_save(0, $urandom, 1'b0);

    // Back-to-back round trip: save, scramble RF, restore right after DONE
    for (int n = 1; n < 32; n++) rf[0][n] = $urandom;
    for (int n = 0; n < 32; n++) orig[n] = (n == 0) ? 32'h0 : rf[0][n];
    pc = $urandom;
    do_save(0, pc, 1'b0);
    for (int n = 1; n < 32; n++) rf[0][n] = $urandom;
    for (int n = 0; n < 32; n++) d[n*32 +: 32] = orig[n];
    do_restore(0, d, pc, 1'b0, 0, 0);

    // Randomized operations across instances
    for (int it = 0; it < 14; it++) begin
      int k;
      k = int'($urandom_range(0, 2));
      for (int gap = int'($urandom_range(0, 3)); gap > 0; gap--) tick();
      if ($urandom_range(0, 1) == 0) begin
        for (int n = 1; n < 32; n++) rf[k][n] = $urandom;
        do_save(k, $urandom, 1'($urandom_range(0, 1)));
      end else begin
        do_restore(k, rnd1024(), $urandom, 1'b1,
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 31)) : 0, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
